cop_mem_responder: RTL and testbench

//  Memory-side responder for the co-processor memory interface (cop_mem_*).

---
 rtl/cop_mem_responder.sv | 151 +++++++++++++++
 tb/tb_cop_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : cop_mem_responder
// Description : Word-wide memory responder for the COP memory interface, with
//               programmable/pseudo-random wait states and range-error reporting.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cop_mem_responder #(
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 1,
    parameter int          RAND_STALL = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cop_mem_cen,
    input  logic        cop_mem_wen,
    input  logic [3:0]  cop_mem_ben,
    input  logic [31:0] cop_mem_addr,
    input  logic [31:0] cop_mem_wdata,
    output logic        cop_mem_stall,
    output logic        cop_mem_error,
    output logic [31:0] cop_mem_rdata
);

    localparam int          c_AW       = $clog2(DEPTH);
    localparam logic [32:0] c_LIMIT    = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
    localparam logic [3:0]  c_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    logic        r_wen;
    logic [3:0]  r_ben;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_error;

    logic [31:0] r_mem [DEPTH];

    logic        w_req_wen;
    logic [3:0]  w_req_ben;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic        w_err;
    logic        w_enter_done;
    logic [c_AW-1:0] w_idx;

    // With zero latency DONE is entered straight from IDLE, before the
    // capture registers are loaded, so the live inputs are used instead.
    assign w_req_wen   = (r_state == ST_IDLE) ? cop_mem_wen   : r_wen;
    assign w_req_ben   = (r_state == ST_IDLE) ? cop_mem_ben   : r_ben;
    assign w_req_addr  = (r_state == ST_IDLE) ? cop_mem_addr  : r_addr;
    assign w_req_wdata = (r_state == ST_IDLE) ? cop_mem_wdata : r_wdata;

    assign w_err = ({1'b0, w_req_addr} < {1'b0, BASE_ADDR}) |
                   ({1'b0, w_req_addr} >= c_LIMIT);
    assign w_idx        = w_req_addr[c_AW+1:2];
    assign w_enter_done = (w_next == ST_DONE) && (r_state != ST_DONE);
    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    assign cop_mem_stall = cop_mem_cen & (r_state != ST_DONE);
    assign cop_mem_error = r_error;
    assign cop_mem_rdata = r_rdata;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (cop_mem_cen) begin
                    w_cnt_next = c_CNT_INIT;
                    w_next     = (LATENCY > 0) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (!cop_mem_cen) begin
                    w_next = ST_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else if ((RAND_STALL != 0) && r_lfsr[0]) begin
                    w_next = ST_WAIT;
                end else begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_lfsr  <= LFSR_SEED;
            r_wen   <= 1'b0;
            r_ben   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == ST_WAIT) begin
                r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            end
            if ((r_state == ST_IDLE) && cop_mem_cen) begin
                r_wen   <= cop_mem_wen;
                r_ben   <= cop_mem_ben;
                r_addr  <= cop_mem_addr;
                r_wdata <= cop_mem_wdata;
            end
            if (w_enter_done) begin
                r_error <= w_err;
                r_rdata <= (w_err || w_req_wen) ? 32'd0 : r_mem[w_idx];
            end else if (r_state == ST_DONE) begin
                r_error <= 1'b0;
                r_rdata <= 32'd0;
            end
        end
    end

    // Storage is deliberately left unreset; reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_done && w_req_wen && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_req_ben[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cop_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_cop_mem_responder
// Description : Scoreboard bench driving four responder instances of differing
//               latency / random-stall configuration.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_cop_mem_responder;

    localparam int          NU     = 4;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] BASE0  = 32'h8000_0100;
    localparam logic [31:0] BASE_O = 32'h0000_1000;
    localparam int          LAT [NU] = '{1, 0, 3, 2};
    localparam bit          RND [NU] = '{0, 0, 0, 1};

    typedef struct {
        int          u;
        bit          err;
        bit          chk;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cen   [NU];
    logic        wen   [NU];
    logic [3:0]  ben   [NU];
    logic [31:0] addr  [NU];
    logic [31:0] wdata [NU];
    logic        stall [NU];
    logic        err   [NU];
    logic [31:0] rdata [NU];

    logic [31:0] mdl  [NU][DEPTH];
    bit          init [NU][DEPTH];
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    cop_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE0), .LATENCY(1), .RAND_STALL(0)) u_dut0 (
        .clk(clk), .reset(reset), .cop_mem_cen(cen[0]), .cop_mem_wen(wen[0]),
        .cop_mem_ben(ben[0]), .cop_mem_addr(addr[0]), .cop_mem_wdata(wdata[0]),
        .cop_mem_stall(stall[0]), .cop_mem_error(err[0]), .cop_mem_rdata(rdata[0]));
    cop_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_O), .LATENCY(0), .RAND_STALL(0)) u_dut1 (
        .clk(clk), .reset(reset), .cop_mem_cen(cen[1]), .cop_mem_wen(wen[1]),
        .cop_mem_ben(ben[1]), .cop_mem_addr(addr[1]), .cop_mem_wdata(wdata[1]),
        .cop_mem_stall(stall[1]), .cop_mem_error(err[1]), .cop_mem_rdata(rdata[1]));
    cop_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_O), .LATENCY(3), .RAND_STALL(0)) u_dut2 (
        .clk(clk), .reset(reset), .cop_mem_cen(cen[2]), .cop_mem_wen(wen[2]),
        .cop_mem_ben(ben[2]), .cop_mem_addr(addr[2]), .cop_mem_wdata(wdata[2]),
        .cop_mem_stall(stall[2]), .cop_mem_error(err[2]), .cop_mem_rdata(rdata[2]));
    cop_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_O), .LATENCY(2), .RAND_STALL(1)) u_dut3 (
        .clk(clk), .reset(reset), .cop_mem_cen(cen[3]), .cop_mem_wen(wen[3]),
        .cop_mem_ben(ben[3]), .cop_mem_addr(addr[3]), .cop_mem_wdata(wdata[3]),
        .cop_mem_stall(stall[3]), .cop_mem_error(err[3]), .cop_mem_rdata(rdata[3]));

    function automatic logic [31:0] base_of(input int u);
        return (u == 0) ? BASE0 : BASE_O;
    endfunction

    function automatic bit out_of_range(input int u, input logic [31:0] a);
        longint la = longint'(a);
        longint lb = longint'(base_of(u));
        return (la < lb) || (la >= lb + DEPTH * 4);
    endfunction

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s unit%0d: got %h, expected %h at %0t", name, u, act, exp, $time);
        end
    endtask

    // Expected response is computed and queued at issue; the monitor below consumes it.
    task automatic xfer(input int u, input bit w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   k;
        int   idx;
        e.u = u;
        e.err = out_of_range(u, a);
        e.chk = 1'b1;
        e.rdata = 32'd0;
        if (!e.err) begin
            idx = int'((a - base_of(u)) >> 2);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mdl[u][idx][8*i +: 8] = d[8*i +: 8];
                if (b == 4'hF) init[u][idx] = 1'b1;
            end else begin
                e.rdata = mdl[u][idx];
                e.chk = init[u][idx];
            end
        end
        sb.push_back(e);
        @(posedge clk); #1;
        cen[u] = 1'b1; wen[u] = w; ben[u] = b; addr[u] = a; wdata[u] = d;
        k = 0;
        forever begin
            @(negedge clk);
            if (!stall[u] || k >= 300) break;
            k++;
        end
        if (stall[u]) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout unit%0d: stall still high after %0d cycles, expected completion", u, k);
        end else if (RND[u]) begin
            n_cmp++;
            if (k < 1 + LAT[u]) begin
                n_bad++;
                $display("FAIL stall_run unit%0d: got %0d cycles, expected >= %0d", u, k, 1 + LAT[u]);
            end
        end else begin
            check("latency", u, k, 1 + LAT[u]);
        end
        @(posedge clk); #1;
        cen[u] = 1'b0;
        wdata[u] = $urandom;
        @(negedge clk);
        check("post_stall", u, {31'd0, stall[u]}, 32'd0);
        check("post_error", u, {31'd0, err[u]}, 32'd0);
        check("post_rdata", u, rdata[u], 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            for (int u = 0; u < NU; u++) begin
                if (cen[u] && !stall[u]) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_completion unit%0d: got a response, expected none", u);
                    end else begin
                        e = sb.pop_front();
                        check("sb_unit", u, u, e.u);
                        check("sb_error", u, {31'd0, err[u]}, {31'd0, e.err});
                        if (e.chk) check("sb_rdata", u, rdata[u], e.rdata);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] a;
        int          u;
        int          r;
        reset = 1'b1;
        for (int i = 0; i < NU; i++) begin
            cen[i] = 1'b0; wen[i] = 1'b0; ben[i] = 4'h0; addr[i] = 32'd0; wdata[i] = 32'd0;
            for (int j = 0; j < DEPTH; j++) begin
                mdl[i][j] = 32'd0; init[i][j] = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NU; i++) begin
            check("reset_stall", i, {31'd0, stall[i]}, 32'd0);
            check("reset_error", i, {31'd0, err[i]}, 32'd0);
            check("reset_rdata", i, rdata[i], 32'd0);
        end

        // Full-word store and readback
        xfer(0, 1, 4'hF, BASE0 + 32'h10, 32'hDEADBEEF);
        xfer(0, 0, 4'hF, BASE0 + 32'h10, 32'h0);
        // Partial byte enables, then an empty-enable store
        xfer(0, 1, 4'hF, BASE0 + 32'h20, 32'hAABBCCDD);
        xfer(0, 1, 4'b0101, BASE0 + 32'h20, 32'h11223344);
        xfer(0, 0, 4'hF, BASE0 + 32'h20, 32'h0);
        xfer(0, 1, 4'b0000, BASE0 + 32'h20, 32'hFFFFFFFF);
        xfer(0, 0, 4'hF, BASE0 + 32'h22, 32'h0);
        // Range edges, including the top of the 32-bit space
        xfer(0, 1, 4'hF, BASE0, 32'h0BADF00D);
        xfer(0, 1, 4'hF, BASE0 + 32'hFC, 32'h5A5A0FF0);
        xfer(0, 0, 4'hF, BASE0 + 32'h100, 32'h0);
        xfer(0, 0, 4'hF, BASE0 - 32'h4, 32'h0);
        xfer(0, 1, 4'hF, BASE0 + 32'h100, 32'hFFFF0000);
        xfer(0, 1, 4'hF, BASE0 - 32'h4, 32'hFFFF0000);
        xfer(0, 1, 4'hF, 32'hFFFF_FFFC, 32'hFFFF0000);
        xfer(0, 0, 4'hF, BASE0, 32'h0);
        xfer(0, 0, 4'hF, BASE0 + 32'hFF, 32'h0);
        // Zero and three-cycle latency
        for (int i = 1; i < 3; i++) begin
            xfer(i, 1, 4'hF, BASE_O + 32'h4, 32'hC0DE0000 + i);
            xfer(i, 0, 4'hF, BASE_O + 32'h4, 32'h0);
            xfer(i, 0, 4'hF, BASE_O + 32'h400, 32'h0);
        end

        // Reset in WAIT drops the store
        xfer(0, 1, 4'hF, BASE0 + 32'h40, 32'hCAFE0001);
        @(posedge clk); #1;
        cen[0] = 1'b1; wen[0] = 1'b1; ben[0] = 4'hF; addr[0] = BASE0 + 32'h40; wdata[0] = 32'h12345678;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; cen[0] = 1'b0;
        @(negedge clk);
        check("rst_wait_stall", 0, {31'd0, stall[0]}, 32'd0);
        check("rst_wait_error", 0, {31'd0, err[0]}, 32'd0);
        check("rst_wait_rdata", 0, rdata[0], 32'd0);
        xfer(0, 0, 4'hF, BASE0 + 32'h40, 32'h0);
        // Requester withdraws during WAIT
        @(posedge clk); #1;
        cen[0] = 1'b1; wen[0] = 1'b1; ben[0] = 4'hF; addr[0] = BASE0 + 32'h40; wdata[0] = 32'h12345678;
        @(posedge clk); #1 cen[0] = 1'b0;
        @(negedge clk);
        check("abort_stall", 0, {31'd0, stall[0]}, 32'd0);
        check("abort_error", 0, {31'd0, err[0]}, 32'd0);
        xfer(0, 0, 4'hF, BASE0 + 32'h40, 32'h0);

        // Randomized traffic over a 16-word window on every instance
        for (int i = 0; i < NU; i++)
            for (int j = 0; j < 16; j++)
                xfer(i, 1, 4'hF, base_of(i) + 32'(4 * j), $urandom);
        for (int n = 0; n < 200; n++) begin
            u = (n % 2 == 0) ? 3 : int'($urandom_range(0, NU - 1));
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = base_of(u) - 32'(4 * $urandom_range(1, 64)) - 32'($urandom_range(0, 3));
            else if (r == 1) a = base_of(u) + 32'(DEPTH * 4) + 32'($urandom_range(0, 1000));
            else             a = base_of(u) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            xfer(u, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
        end

        repeat (2) @(posedge clk);
        check("sb_drained", 0, 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
